// File: rtl/quad_step_decoder.sv
`default_nettype none
// ============================================================================
// Module   : quad_step_decoder
// Brief    : Synchronises and glitch-filters quadrature phases A/B, decodes
//            Gray-code transitions into Step/UpOrDown and flags illegal jumps.
// Revision : 1.0 - initial release
// ============================================================================
module quad_step_decoder #(
    parameter int FILTER_LEN = 4,
    parameter int FCNT_W     = 4
) (
    input  logic Clk,
    input  logic reset,
    input  logic A,
    input  logic B,
    input  logic ErrClr,
    output logic Step,
    output logic UpOrDown,
    output logic Err,
    output logic Ready
);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [FCNT_W-1:0] c_fcnt_max = FCNT_W'(FILTER_LEN - 1);
    localparam logic [1:0]        c_init_end = 2'd2;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_init_done;
    logic              w_run;

    // Phase vectors are packed as {A, B}, bit 1 = A, bit 0 = B.
    logic [1:0]        r_sync1;
    logic [1:0]        r_sync2;
    logic [1:0]        r_filt;
    logic [1:0]        r_prev;
    logic [FCNT_W-1:0] r_fcnt [2];
    logic [1:0]        r_init_cnt;

    logic              w_up;
    logic              w_down;
    logic              w_illegal;

    function automatic logic [1:0] f_next_up(input logic [1:0] ab);
        logic [1:0] v_nxt;
        case (ab)
            2'b00:   v_nxt = 2'b10;
            2'b10:   v_nxt = 2'b11;
            2'b11:   v_nxt = 2'b01;
            default: v_nxt = 2'b00;
        endcase
        return v_nxt;
    endfunction

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_init_done = 1'b0;
        w_run       = 1'b0;
        case (r_state)
            ST_INIT: begin
                if (r_init_cnt == c_init_end) begin
                    w_init_done = 1'b1;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                w_run = 1'b1;
            end
            default: begin
                w_state_nxt = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            r_sync1    <= 2'b00;
            r_sync2    <= 2'b00;
            r_init_cnt <= 2'd0;
        end else begin
            r_sync1 <= {A, B};
            r_sync2 <= r_sync1;
            if (r_state == ST_INIT) begin
                r_init_cnt <= r_init_cnt + 2'd1;
            end
        end
    end

    // INIT seeds the filters with the settled inputs so a phase that is
    // already high at reset release does not look like a transition.
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            r_filt <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                r_fcnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (w_init_done) begin
                    r_filt[i] <= r_sync2[i];
                    r_fcnt[i] <= '0;
                end else if (w_run) begin
                    if (r_sync2[i] == r_filt[i]) begin
                        r_fcnt[i] <= '0;
                    end else if (r_fcnt[i] == c_fcnt_max) begin
                        r_filt[i] <= r_sync2[i];
                        r_fcnt[i] <= '0;
                    end else begin
                        r_fcnt[i] <= r_fcnt[i] + FCNT_W'(1);
                    end
                end
            end
        end
    end

    always_comb begin
        w_up      = (r_filt == f_next_up(r_prev));
        w_down    = (r_prev == f_next_up(r_filt));
        w_illegal = (r_filt == ~r_prev);
    end

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            Step     <= 1'b0;
            UpOrDown <= 1'b1;
            Ready    <= 1'b0;
            r_prev   <= 2'b00;
        end else begin
            Step <= 1'b0;
            if (w_init_done) begin
                r_prev <= r_sync2;
                Ready  <= 1'b1;
            end else if (w_run) begin
                r_prev <= r_filt;
                if (w_up) begin
                    Step     <= 1'b1;
                    UpOrDown <= 1'b1;
                end else if (w_down) begin
                    Step     <= 1'b1;
                    UpOrDown <= 1'b0;
                end
            end
        end
    end

    // A detection on the same edge as a clear request takes priority.
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            Err <= 1'b0;
        end else if (w_run && w_illegal) begin
            Err <= 1'b1;
        end else if (ErrClr) begin
            Err <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_quad_step_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_quad_step_decoder
// Brief    : Self-checking bench for quad_step_decoder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_quad_step_decoder;

    localparam int FILT = 4;
    localparam int LAT  = FILT + 3;

    logic Clk;
    logic reset;
    logic A;
    logic B;
    logic ErrClr;
    logic Step;
    logic UpOrDown;
    logic Err;
    logic Ready;

    quad_step_decoder #(
        .FILTER_LEN(FILT),
        .FCNT_W    (4)
    ) dut (
        .Clk     (Clk),
        .reset   (reset),
        .A       (A),
        .B       (B),
        .ErrClr  (ErrClr),
        .Step    (Step),
        .UpOrDown(UpOrDown),
        .Err     (Err),
        .Ready   (Ready)
    );

    typedef struct {
        logic dir;
        int   t0;
        int   lat;
    } exp_t;

    typedef struct {
        logic [1:0] ab;
        int         hold;
        logic       step;
        logic       dir;
        logic       err;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[8];
    int   n_checks  = 0;
    int   n_errors  = 0;
    int   cyc       = 0;
    logic prev_step = 1'b0;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock edge, then settle and score any Step pulse.
    task automatic tick();
        exp_t e;
        @(posedge Clk);
        #1;
        cyc++;
        if (Step) begin
            check("step_width", prev_step, 0);
            if (exp_q.size() == 0) begin
                check("unexpected_step", Step, 0);
            end else begin
                e = exp_q.pop_front();
                check("step_dir", UpOrDown, e.dir);
                check("step_latency", cyc - e.t0, e.lat);
            end
        end
        prev_step = Step;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic expect_step(input logic dir, input int t0);
        exp_t e;
        e.dir = dir;
        e.t0  = t0;
        e.lat = LAT;
        exp_q.push_back(e);
    endtask

    task automatic do_reset(input logic a, input logic b);
        A     = a;
        B     = b;
        reset = 1'b0;
        ticks(2);
        check("rst_step", Step, 0);
        check("rst_dir", UpOrDown, 1);
        check("rst_err", Err, 0);
        check("rst_ready", Ready, 0);
        reset = 1'b1;
        ticks(2);
        check("ready_early", Ready, 0);
        tick();
        check("ready_rise", Ready, 1);
    endtask

    initial begin
        reset  = 1'b0;
        A      = 1'b1;
        B      = 1'b1;
        ErrClr = 1'b0;

        vecs[0] = '{2'b10, 10, 1'b1, 1'b1, 1'b0};
        vecs[1] = '{2'b11, 10, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{2'b01, 10, 1'b1, 1'b1, 1'b0};
        vecs[3] = '{2'b00, 10, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{2'b01, 10, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{2'b11, 10, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{2'b10, 10, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{2'b00, 10, 1'b1, 1'b0, 1'b0};

        // Reset release with both phases high: no spurious step or error.
        do_reset(1'b1, 1'b1);
        ticks(10);
        check("hi_release_err", Err, 0);
        check("hi_release_q", exp_q.size(), 0);

        do_reset(1'b0, 1'b0);

        // Up then down Gray sequences.
        for (int v = 0; v < 8; v++) begin
            {A, B} = vecs[v].ab;
            if (vecs[v].step) expect_step(vecs[v].dir, cyc);
            ticks(vecs[v].hold);
            check("vec_missing_step", exp_q.size(), 0);
            check("vec_err", Err, vecs[v].err);
            check("vec_dir_hold", UpOrDown, vecs[v].dir);
        end

        // Glitch one cycle shorter than the filter is discarded.
        A = 1'b1;
        ticks(FILT - 1);
        A = 1'b0;
        ticks(8);
        check("glitch_q", exp_q.size(), 0);
        check("glitch_err", Err, 0);

        // Pulse exactly FILTER_LEN long produces an up then a down step.
        A = 1'b1;
        expect_step(1'b1, cyc);
        ticks(FILT);
        A = 1'b0;
        expect_step(1'b0, cyc);
        ticks(12);
        check("min_pulse_q", exp_q.size(), 0);
        check("min_pulse_err", Err, 0);

        // Illegal 00 -> 11: sticky error, direction untouched, clearable.
        {A, B} = 2'b11;
        ticks(LAT - 1);
        check("illegal_not_yet", Err, 0);
        tick();
        check("illegal_set", Err, 1);
        ticks(10);
        check("illegal_sticky", Err, 1);
        check("illegal_dir_hold", UpOrDown, 0);
        ErrClr = 1'b1;
        tick();
        ErrClr = 1'b0;
        check("errclr", Err, 0);
        ticks(2);
        check("errclr_hold", Err, 0);

        // Illegal 11 -> 00 with clear on the detection edge: set wins.
        {A, B} = 2'b00;
        ticks(LAT - 1);
        check("illegal2_not_yet", Err, 0);
        ErrClr = 1'b1;
        tick();
        ErrClr = 1'b0;
        check("set_wins", Err, 1);
        ticks(5);
        check("set_wins_sticky", Err, 1);

        // Reset while a transition is still in the filter.
        A = 1'b1;
        ticks(4);
        reset = 1'b0;
        #1;
        check("midrst_ready", Ready, 0);
        check("midrst_step", Step, 0);
        check("midrst_err", Err, 0);
        tick();
        reset = 1'b1;
        ticks(2);
        check("midrst_ready_early", Ready, 0);
        tick();
        check("midrst_ready_rise", Ready, 1);
        ticks(12);
        check("midrst_err_after", Err, 0);
        check("midrst_q", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
